// File: rtl/mem_access_stage.sv
// MIPS MEM stage: maps byte-addressed loads/stores onto a word-addressed data memory.
// Sub-word stores are done as a two-cycle read-modify-write and hold upstream for one cycle.
module mem_access_stage #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_clk_mips,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [4:0]        i_rd,
    input  logic              i_reg_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              o_stall,
    output logic              o_misalign,
    output logic              o_wb_valid,
    output logic              o_wb_reg_write,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [4:0]        o_wb_rd
);
    typedef enum logic [0:0] {ST_IDLE, ST_RMW_WRITE} state_t;

    state_t              state_q, state_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic                misalign_q, misalign_d;
    logic [DATA_W-1:0]   rmw_word_q, rmw_word_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic                rmw_byte_q, rmw_byte_d;
    logic [1:0]          rmw_off_q, rmw_off_d;
    logic [15:0]         rmw_wdata_q, rmw_wdata_d;

    logic              is_mem, is_load, is_byte, is_half, misalign;
    logic              rd_req, wr_req;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_data, merged;

    assign is_mem   = i_mem_read | i_mem_write;
    assign is_load  = i_mem_read & ~i_mem_write;
    assign is_byte  = (i_size == 2'b00);
    assign is_half  = (i_size == 2'b01);
    // Reserved size 11 falls into the word case.
    assign misalign = (is_half & i_addr[0]) | (~is_byte & ~is_half & (i_addr[1:0] != 2'b00));

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        ld_byte = mem_rdata[31:24];
        case (i_addr[1:0])
            2'd0: ld_byte = mem_rdata[31:24];
            2'd1: ld_byte = mem_rdata[23:16];
            2'd2: ld_byte = mem_rdata[15:8];
            2'd3: ld_byte = mem_rdata[7:0];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = i_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        if (is_byte)
            load_data = {{24{ld_byte[7] & ~i_unsigned}}, ld_byte};
        else if (is_half)
            load_data = {{16{ld_half[15] & ~i_unsigned}}, ld_half};
        else
            load_data = mem_rdata;
    end

    always_comb begin
        merged = rmw_word_q;
        if (rmw_byte_q) begin
            case (rmw_off_q)
                2'd0: merged[31:24] = rmw_wdata_q[7:0];
                2'd1: merged[23:16] = rmw_wdata_q[7:0];
                2'd2: merged[15:8]  = rmw_wdata_q[7:0];
                2'd3: merged[7:0]   = rmw_wdata_q[7:0];
                default: merged = rmw_word_q;
            endcase
        end else if (rmw_off_q[1]) begin
            merged[15:0] = rmw_wdata_q;
        end else begin
            merged[31:16] = rmw_wdata_q;
        end
    end

    // Strobes are gated by reset so an abort during RMW_WRITE never reaches memory.
    always_comb begin
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        o_stall   = 1'b0;
        mem_addr  = i_addr[ADDR_W+1:2];
        mem_wdata = i_wdata;
        if (state_q == ST_RMW_WRITE) begin
            mem_addr  = rmw_addr_q;
            mem_wdata = merged;
            wr_req    = 1'b1;
        end else if (i_valid && is_mem && !misalign) begin
            if (i_mem_write) begin
                if (is_byte || is_half) begin
                    rd_req  = 1'b1;
                    o_stall = 1'b1;
                end else begin
                    wr_req = 1'b1;
                end
            end else begin
                rd_req = 1'b1;
            end
        end
        mem_rd = rd_req & ctrl_clk_mips & ~rst;
        mem_wr = wr_req & ctrl_clk_mips & ~rst;
    end

    always_comb begin
        state_d        = state_q;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        misalign_d     = 1'b0;
        rmw_word_d     = rmw_word_q;
        rmw_addr_d     = rmw_addr_q;
        rmw_byte_d     = rmw_byte_q;
        rmw_off_d      = rmw_off_q;
        rmw_wdata_d    = rmw_wdata_q;
        if (state_q == ST_RMW_WRITE) begin
            state_d        = ST_IDLE;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
        end else if (!i_valid) begin
            wb_valid_d = 1'b0;
        end else if (is_mem && misalign) begin
            misalign_d     = 1'b1;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_data_d      = i_addr;
            wb_rd_d        = i_rd;
        end else if (i_mem_write && (is_byte || is_half)) begin
            state_d     = ST_RMW_WRITE;
            wb_valid_d  = 1'b0;
            rmw_word_d  = mem_rdata;
            rmw_addr_d  = i_addr[ADDR_W+1:2];
            rmw_byte_d  = is_byte;
            rmw_off_d   = i_addr[1:0];
            rmw_wdata_d = i_wdata[15:0];
        end else if (i_mem_write) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_data_d      = i_addr;
            wb_rd_d        = i_rd;
        end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = i_reg_write;
            wb_data_d      = is_load ? load_data : i_addr;
            wb_rd_d        = i_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            misalign_q     <= 1'b0;
            rmw_word_q     <= '0;
            rmw_addr_q     <= '0;
            rmw_byte_q     <= 1'b0;
            rmw_off_q      <= '0;
            rmw_wdata_q    <= '0;
        end else if (ctrl_clk_mips) begin
            state_q        <= state_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            misalign_q     <= misalign_d;
            rmw_word_q     <= rmw_word_d;
            rmw_addr_q     <= rmw_addr_d;
            rmw_byte_q     <= rmw_byte_d;
            rmw_off_q      <= rmw_off_d;
            rmw_wdata_q    <= rmw_wdata_d;
        end
    end

    assign o_misalign     = misalign_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_wb_data      = wb_data_q;
    assign o_wb_rd        = wb_rd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural word memory on the memory port.
module tb_mem_access_stage;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              ctrl_clk_mips;
    logic              i_valid, i_mem_read, i_mem_write, i_unsigned, i_reg_write;
    logic [1:0]        i_size;
    logic [31:0]       i_addr, i_wdata;
    logic [4:0]        i_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata, o_wb_data;
    logic              mem_wr, mem_rd, o_stall, o_misalign, o_wb_valid, o_wb_reg_write;
    logic [4:0]        o_wb_rd;

    logic [31:0]       mem_model [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ctrl_clk_mips(ctrl_clk_mips),
        .i_valid(i_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rd(i_rd), .i_reg_write(i_reg_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .o_stall(o_stall), .o_misalign(o_misalign),
        .o_wb_valid(o_wb_valid), .o_wb_reg_write(o_wb_reg_write),
        .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd)
    );

    assign mem_rdata = mem_model[mem_addr];
    always @(posedge clk) begin
        if (pre_we)      mem_model[pre_addr] <= pre_data;
        else if (mem_wr) mem_model[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Apply one EX/MEM slot at the negedge, leaving 1 time unit for combinational settling.
    task automatic op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] r, input logic rw);
        @(negedge clk);
        i_valid = v; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
        i_addr = a; i_wdata = wd; i_rd = r; i_reg_write = rw;
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ctrl_clk_mips = 1'b1;
        i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_size = 2'b10; i_unsigned = 0;
        i_addr = 0; i_wdata = 0; i_rd = 0; i_reg_write = 0;
        preload(6'd5, 32'h8899AABB);
        preload(6'd1, 32'hDEADBEEF);
        preload(6'd8, 32'h0);
        @(negedge clk); #1;
        chk("rst_wb_valid", {31'b0, o_wb_valid}, 32'h0);
        chk("rst_wb_data", o_wb_data, 32'h0);
        chk("rst_misalign", {31'b0, o_misalign}, 32'h0);
        chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
        rst = 1'b0;

        // LB 0x15
        op(1, 1, 0, 2'b00, 0, 32'h15, 0, 5'd3, 1);
        chk("lb_rd", {31'b0, mem_rd}, 32'h1);
        chk("lb_addr", {26'b0, mem_addr}, 32'h5);
        chk("lb_stall", {31'b0, o_stall}, 32'h0);
        tick();
        chk("lb_data", o_wb_data, 32'hFFFFFF99);
        chk("lb_wbv", {31'b0, o_wb_valid}, 32'h1);
        chk("lb_regw", {31'b0, o_wb_reg_write}, 32'h1);
        chk("lb_wbrd", {27'b0, o_wb_rd}, 32'h3);

        op(1, 1, 0, 2'b00, 1, 32'h15, 0, 5'd4, 1);
        tick();
        chk("lbu_data", o_wb_data, 32'h00000099);

        op(1, 1, 0, 2'b01, 0, 32'h16, 0, 5'd5, 1);
        tick();
        chk("lh_data", o_wb_data, 32'hFFFFAABB);

        op(1, 1, 0, 2'b01, 1, 32'h14, 0, 5'd5, 1);
        tick();
        chk("lhu_data", o_wb_data, 32'h00008899);

        // SW 0x12345678 at 0x20
        op(1, 0, 1, 2'b10, 0, 32'h20, 32'h12345678, 5'd0, 0);
        chk("sw_wr", {30'b0, mem_rd, mem_wr}, 32'h1);
        chk("sw_addr", {26'b0, mem_addr}, 32'h8);
        chk("sw_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("sw_regw", {30'b0, o_wb_valid, o_wb_reg_write}, 32'h2);
        idle();
        chk("sw_pulse", {31'b0, mem_wr}, 32'h0);
        tick();
        chk("bubble_wbv", {31'b0, o_wb_valid}, 32'h0);

        op(1, 1, 0, 2'b10, 0, 32'h20, 0, 5'd7, 1);
        tick();
        chk("lw_data", o_wb_data, 32'h12345678);

        // SB 0xCC at 0x16: read phase then write phase
        op(1, 0, 1, 2'b00, 0, 32'h16, 32'h000000CC, 5'd0, 0);
        chk("sb_c1_strobes", {30'b0, mem_rd, mem_wr}, 32'h2);
        chk("sb_c1_stall", {31'b0, o_stall}, 32'h1);
        tick();
        chk("sb_bubble", {31'b0, o_wb_valid}, 32'h0);
        idle();
        chk("sb_c2_strobes", {30'b0, mem_rd, mem_wr}, 32'h1);
        chk("sb_c2_wdata", mem_wdata, 32'h8899CCBB);
        chk("sb_c2_addr", {26'b0, mem_addr}, 32'h5);
        chk("sb_c2_stall", {31'b0, o_stall}, 32'h0);
        tick();
        chk("sb_wb", {30'b0, o_wb_valid, o_wb_reg_write}, 32'h2);

        op(1, 1, 0, 2'b10, 0, 32'h14, 0, 5'd8, 1);
        tick();
        chk("lw_after_sb", o_wb_data, 32'h8899CCBB);

        // Misaligned LH at 0x13
        op(1, 1, 0, 2'b01, 0, 32'h13, 0, 5'd9, 1);
        chk("mis_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
        tick();
        chk("mis_flag", {31'b0, o_misalign}, 32'h1);
        chk("mis_wb", {30'b0, o_wb_valid, o_wb_reg_write}, 32'h2);
        idle();
        tick();
        chk("mis_pulse_end", {31'b0, o_misalign}, 32'h0);

        // Misaligned SW at 0x22
        op(1, 0, 1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 5'd0, 0);
        chk("mis_sw_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
        tick();
        chk("mis_sw_flag", {31'b0, o_misalign}, 32'h1);

        // SH at 0x14 aborted by reset during its write phase
        op(1, 0, 1, 2'b01, 0, 32'h14, 32'h00001234, 5'd0, 0);
        tick();
        idle();
        chk("sh_wr_before_rst", {31'b0, mem_wr}, 32'h1);
        chk("sh_wdata", mem_wdata, 32'h1234CCBB);
        rst = 1'b1;
        #1;
        chk("sh_rst_wr", {31'b0, mem_wr}, 32'h0);
        chk("sh_rst_wbdata", o_wb_data, 32'h0);
        chk("sh_rst_wbvalid", {31'b0, o_wb_valid}, 32'h0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        chk("sh_mem_unchanged", mem_model[5], 32'h8899CCBB);

        op(1, 1, 0, 2'b10, 0, 32'h14, 0, 5'd10, 1);
        chk("idle_after_rst", {29'b0, o_stall, mem_rd, mem_wr}, 32'h2);
        tick();
        chk("lw_after_rst", o_wb_data, 32'h8899CCBB);

        // Frozen load at 0x104 (wraps to word 1), then released
        ctrl_clk_mips = 1'b0;
        op(1, 1, 0, 2'b10, 0, 32'h104, 0, 5'd11, 1);
        chk("frz_rd", {31'b0, mem_rd}, 32'h0);
        chk("frz_addr", {26'b0, mem_addr}, 32'h1);
        tick();
        chk("frz_wbdata", o_wb_data, 32'h8899CCBB);
        chk("frz_wbrd", {27'b0, o_wb_rd}, 32'hA);
        @(negedge clk);
        ctrl_clk_mips = 1'b1;
        #1;
        chk("unfrz_rd", {31'b0, mem_rd}, 32'h1);
        tick();
        chk("wrap_data", o_wb_data, 32'hDEADBEEF);
        chk("wrap_wbrd", {27'b0, o_wb_rd}, 32'hB);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS MEM pipeline stage between the EX/MEM register and the word-addressed data memory; drives its Addr/In_Data/Wr/Rd and consumes its read data.
- Converts byte addresses and LB/LBU/LH/LHU/LW/SB/SH/SW into word accesses.
- Sub-word stores use a 2-cycle read-modify-write (RMW) and stall upstream.
- Result goes into an internal MEM/WB register.

Parameters:
ADDR_W, 6, word-address width driven to data memory (depth 2^ADDR_W words)
DATA_W, 32, data width; fixed at 32

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
ctrl_clk_mips  in  1  step enable from debug unit; 0 = freeze all state, no memory strobes
i_valid  in  1  EX/MEM slot holds an instruction
i_mem_read  in  1  load
i_mem_write  in  1  store
i_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_unsigned  in  1  zero-extend loads (LBU/LHU)
i_addr  in  32  ALU result = byte address; also pass-through result
i_wdata  in  32  store data (rt)
i_rd  in  5  destination register
i_reg_write  in  1  instruction writes a register
mem_addr  out  ADDR_W  word address = i_addr[ADDR_W+1:2] (upper bits ignored; wraps modulo depth)
mem_wdata  out  32  word to write
mem_wr  out  1  write strobe
mem_rd  out  1  read strobe
mem_rdata  in  32  data memory output; valid before the posedge of the cycle mem_rd is high
o_stall  out  1  upstream must hold EX/MEM contents this cycle
o_misalign  out  1  registered 1-cycle pulse: misaligned access dropped
o_wb_valid, o_wb_reg_write  out  1 each  MEM/WB valid, register write enable
o_wb_data  out  32  load data or pass-through i_addr
o_wb_rd  out  5  destination register

Behaviour:
- Byte order big-endian: offset 0 = bits[31:24], offset 3 = bits[7:0]; halfword offset 0 = [31:16].
- Reset: FSM=IDLE; o_wb_* = 0; o_misalign=0. Strobes drop immediately (combinational from state/inputs). A reset during RMW_WRITE aborts the write.
- ctrl_clk_mips=0: mem_wr=mem_rd=0; FSM, MEM/WB and o_misalign hold; o_stall holds its decoded value.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0) and valid read/write:
  - no strobes;
  - next posedge: o_misalign=1, o_wb_valid=1, o_wb_reg_write=0.
- FSM IDLE, with en=1 and i_valid=1:
  - No mem op: posedge loads o_wb_data=i_addr, o_wb_rd, o_wb_reg_write=i_reg_write, o_wb_valid=1.
  - Load: mem_rd=1 same cycle; posedge latches the selected byte/half/word of mem_rdata (sign/zero-extended per i_unsigned) into o_wb_data; latency 1, no stall.
  - SW: mem_wr=1, mem_wdata=i_wdata; 1 cycle; o_wb_reg_write=0.
  - SB/SH:
    - mem_rd=1, o_stall=1.
    - Posedge captures mem_rdata, addr, size, offset and wdata into RMW registers.
    - o_wb_valid<=0 (bubble); go to RMW_WRITE.
  - i_valid=0: o_wb_valid<=0.
- FSM RMW_WRITE:
  - mem_wr=1, mem_addr from captured addr.
  - mem_wdata = captured word with the target byte/half replaced by i_wdata[7:0]/[15:0].
  - o_stall=0; posedge: o_wb_valid=1, o_wb_reg_write=0, go to IDLE. Inputs are ignored in this cycle.
- mem_rd and mem_wr are never high in the same cycle.
- i_mem_read and i_mem_write both high: treated as store; no read result.
- Reserved size 11 behaves as word.

Test Plan:
- Preload word 5 = 0x8899AABB. LB at addr 0x15 → o_wb_data=0xFFFFFF99 one cycle later, no stall. LBU at 0x15 → 0x00000099. LH at 0x16 → 0xFFFFAABB.
- SW 0x12345678 at 0x20 → mem_wr pulse for 1 cycle, addr 8. Then LW 0x20 → 0x12345678.
- Word 5 = 0x8899AABB; SB wdata 0x000000CC at 0x16:
  - cycle 1: mem_rd=1, o_stall=1;
  - cycle 2: mem_wr=1, mem_wdata=0x8899CCBB;
  - LW 0x14 then → 0x8899CCBB.
- LH at 0x13 → no strobes, o_misalign=1 for exactly 1 cycle, o_wb_reg_write=0.
- SH in RMW_WRITE with rst asserted mid-cycle → mem_wr drops immediately, memory word unchanged, FSM=IDLE, o_wb_* = 0.
- ctrl_clk_mips=0 during a load → no mem_rd, outputs frozen. Re-enable → load completes with correct data. Addr 0x104 (ADDR_W=6) wraps to word 1.
